// File: rtl/branch_fwd_hazard_ctrl.sv
// ID-stage branch operand forwarding and hazard stall control for beq/bne.
// Selects/stall are combinational from state and inputs; only FSM and counters register. No backpressure beyond hold.
module branch_fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             id_branch,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             branch_eq,
  input  logic             id_is_bne,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic             branch_valid,
  output logic             taken,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STALL2 = 1'b1;

  localparam logic [1:0] SEL_CUR = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic ex_hit, mem_hit;
  logic mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b;
  logic [1:0] need_n;

  // Register $0 is hardwired, so a write to it never creates a dependency.
  assign ex_hit  = ex_regwrite  && (ex_rd  != 5'd0) && ((ex_rd  == id_rs) || (ex_rd  == id_rt));
  assign mem_hit = mem_regwrite && (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt));

  assign mem_fwd_a = mem_regwrite && !mem_memread && (mem_rd != 5'd0) && (mem_rd == id_rs);
  assign mem_fwd_b = mem_regwrite && !mem_memread && (mem_rd != 5'd0) && (mem_rd == id_rt);
  assign wb_fwd_a  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs);
  assign wb_fwd_b  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rt);

  always_comb begin
    need_n = 2'd0;
    if (id_branch) begin
      if (ex_hit && ex_memread)        need_n = 2'd2;
      else if (ex_hit)                 need_n = 2'd1;
      else if (mem_hit && mem_memread) need_n = 2'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    branch_valid = 1'b0;
    sel_a        = SEL_CUR;
    sel_b        = SEL_CUR;
    if (reset) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_STALL2: begin
          stall   = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          if (id_branch) begin
            if (need_n != 2'd0) begin
              stall   = 1'b1;
              state_d = (need_n == 2'd2) ? S_STALL2 : S_IDLE;
            end else begin
              branch_valid = 1'b1;
              sel_a = mem_fwd_a ? SEL_MEM : (wb_fwd_a ? SEL_WB : SEL_CUR);
              sel_b = mem_fwd_b ? SEL_MEM : (wb_fwd_b ? SEL_WB : SEL_CUR);
            end
          end
        end
      endcase
    end
  end

  assign taken    = branch_valid && (branch_eq ^ id_is_bne);
  assign if_flush = taken;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    taken_cnt_d    = taken_cnt_q;
    if (stall && (stall_cycles_q != {CNT_W{1'b1}})) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (taken && (taken_cnt_q != {CNT_W{1'b1}}))    taken_cnt_d    = taken_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      stall_cycles_q <= '0;
      taken_cnt_q    <= '0;
    end else if (!hold) begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      taken_cnt_q    <= taken_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_branch_fwd_hazard_ctrl.sv
// Directed bench for branch_fwd_hazard_ctrl; a second instance with CNT_W=2 covers counter saturation.
module tb_branch_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, hold, id_branch, branch_eq, id_is_bne;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;

  logic [1:0]  sel_a, sel_b, sel_a2, sel_b2;
  logic        stall, branch_valid, taken, if_flush;
  logic        stall2, branch_valid2, taken2, if_flush2;
  logic [15:0] stall_cycles, taken_cnt;
  logic [1:0]  stall_cycles2, taken_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_fwd_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hold(hold), .id_branch(id_branch),
    .id_rs(id_rs), .id_rt(id_rt), .branch_eq(branch_eq), .id_is_bne(id_is_bne),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .branch_valid(branch_valid),
    .taken(taken), .if_flush(if_flush), .stall_cycles(stall_cycles), .taken_cnt(taken_cnt)
  );

  branch_fwd_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .hold(hold), .id_branch(id_branch),
    .id_rs(id_rs), .id_rt(id_rt), .branch_eq(branch_eq), .id_is_bne(id_is_bne),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .sel_a(sel_a2), .sel_b(sel_b2), .stall(stall2), .branch_valid(branch_valid2),
    .taken(taken2), .if_flush(if_flush2), .stall_cycles(stall_cycles2), .taken_cnt(taken_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0;
  endtask

  initial begin
    reset = 1; hold = 1; id_branch = 1; branch_eq = 1; id_is_bne = 0;
    id_rs = 5'd3; id_rt = 5'd4;
    clear_pipe();
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
    step(); step();
    #1;
    check("rst_stall", stall, 0);
    check("rst_bv", branch_valid, 0);
    check("rst_taken", taken, 0);
    check("rst_flush", if_flush, 0);
    check("rst_sel_a", sel_a, 0);
    check("rst_stall_cnt", stall_cycles, 0);
    check("rst_taken_cnt", taken_cnt, 0);

    // ALU producer in EX: one stall, then forward from EX/MEM.
    reset = 0; hold = 0; branch_eq = 0;
    clear_pipe();
    id_rs = 5'd8; id_rt = 5'd0; ex_regwrite = 1; ex_rd = 5'd8;
    #1;
    check("alu_c0_stall", stall, 1);
    check("alu_c0_sel_a", sel_a, 0);
    check("alu_c0_bv", branch_valid, 0);
    step();
    clear_pipe();
    mem_regwrite = 1; mem_rd = 5'd8;
    #1;
    check("alu_c1_stall", stall, 0);
    check("alu_c1_sel_a", sel_a, 2);
    check("alu_c1_bv", branch_valid, 1);
    check("alu_c1_taken", taken, 0);
    check("alu_c1_stall_cnt", stall_cycles, 1);

    // Load in EX feeding rt: two stalls, then forward from MEM/WB.
    step();
    clear_pipe();
    id_rs = 5'd9; id_rt = 5'd10; branch_eq = 1;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd10;
    #1;
    check("ld_c0_stall", stall, 1);
    step();
    clear_pipe();
    mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd10;
    #1;
    check("ld_c1_stall", stall, 1);
    check("ld_c1_bv", branch_valid, 0);
    check("ld_c1_sel_b", sel_b, 0);
    step();
    clear_pipe();
    wb_regwrite = 1; wb_rd = 5'd10;
    #1;
    check("ld_c2_stall", stall, 0);
    check("ld_c2_sel_b", sel_b, 1);
    check("ld_c2_sel_a", sel_a, 0);
    check("ld_c2_taken", taken, 1);
    check("ld_c2_flush", if_flush, 1);
    step();
    id_branch = 0;
    #1;
    check("ld_taken_cnt", taken_cnt, 1);
    check("ld_stall_cnt", stall_cycles, 3);
    check("nobr_bv", branch_valid, 0);

    // Writes to $0 never create a hazard.
    id_branch = 1; id_rs = 5'd0; id_rt = 5'd0; branch_eq = 0;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 0;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 0;
    wb_regwrite = 1; wb_rd = 0;
    #1;
    check("r0_stall", stall, 0);
    check("r0_sel_a", sel_a, 0);
    check("r0_sel_b", sel_b, 0);
    check("r0_bv", branch_valid, 1);

    // EX/MEM beats MEM/WB; bne with equal operands is not taken.
    clear_pipe();
    id_rs = 5'd5; id_rt = 5'd0; id_is_bne = 1; branch_eq = 1;
    mem_regwrite = 1; mem_rd = 5'd5; wb_regwrite = 1; wb_rd = 5'd5;
    #1;
    check("prio_sel_a", sel_a, 2);
    check("prio_taken", taken, 0);
    check("prio_flush", if_flush, 0);
    branch_eq = 0;
    #1;
    check("bne_ne_taken", taken, 1);

    // Hold while in STALL2 freezes state and counters.
    id_branch = 0; id_is_bne = 0;
    clear_pipe();
    reset = 1;
    step();
    reset = 0; id_branch = 1; id_rs = 5'd7; id_rt = 5'd0;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd7;
    #1;
    check("hold_c0_stall", stall, 1);
    step();
    clear_pipe();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", stall, 1);
      check("hold_cnt", stall_cycles, 1);
      step();
    end
    hold = 0;
    #1;
    check("unhold_stall", stall, 1);
    step();
    #1;
    check("post_stall2_stall", stall, 0);
    check("post_stall2_bv", branch_valid, 1);
    check("post_stall2_cnt", stall_cycles, 2);
    check("post_stall2_cnt_sat", stall_cycles2, 2);

    // Reset in STALL2 with hold and a live branch hazard.
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd7;
    step();
    #1;
    check("pre_rst_stall2", stall, 1);
    reset = 1; hold = 1;
    #1;
    check("rst2_stall", stall, 0);
    step();
    reset = 0; hold = 0;
    clear_pipe();
    #1;
    check("rst2_idle_stall", stall, 0);
    check("rst2_idle_bv", branch_valid, 1);
    check("rst2_cnt", stall_cycles, 0);
    check("rst2_cnt_sat", stall_cycles2, 0);

    // Five consecutive stall cycles: 2-bit counter sticks at 3.
    ex_regwrite = 1; ex_memread = 0; ex_rd = 5'd7;
    for (int i = 0; i < 5; i++) step();
    #1;
    check("sat_cnt_wide", stall_cycles, 5);
    check("sat_cnt_narrow", stall_cycles2, 3);
    check("sat_taken_cnt", taken_cnt2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_fwd_hazard_ctrl.md
Name: branch_fwd_hazard_ctrl

Overview:
- Controller for the two ID-stage branch-comparator forwarding muxes: one mux for the rs operand, one for the rt operand.
- Each mux selects one of three sources: the current register-file value, the EX/MEM result or the MEM/WB result.
- For beq/bne resolved in ID, it computes both mux selects and sequences the stall cycles needed when a producer's result is not yet forwardable.
- It also issues the IF/ID flush for taken branches and keeps saturating stall and taken-branch counters.

Parameters:
- CNT_W, 16, width of the perf counters stall_cycles and taken_cnt.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  global pipeline freeze; FSM and counters hold, outputs still computed.
- id_branch  in  1  beq/bne decoded in ID.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- branch_eq  in  1  comparator result (operands equal) on the forwarded operands.
- id_is_bne  in  1  1 = bne, 0 = beq.
- ex_regwrite  in  1  EX-stage instruction writes the register file.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rd  in  5  EX-stage destination register, after the RegDst mux.
- mem_regwrite  in  1  MEM-stage instruction writes the register file.
- mem_memread  in  1  MEM-stage instruction is a load.
- mem_rd  in  5  MEM-stage destination register.
- wb_regwrite  in  1  WB-stage instruction writes the register file.
- wb_rd  in  5  WB-stage destination register.
- sel_a  out  2  rs mux select: 00 current, 01 mem_wb, 10 ex_mem; 11 never driven.
- sel_b  out  2  rt mux select, same encoding.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- branch_valid  out  1  comparator result is valid and used this cycle.
- taken  out  1  branch_valid & (branch_eq ^ id_is_bne).
- if_flush  out  1  equals taken; flush IF/ID.
- stall_cycles  out  CNT_W  count of cycles with stall=1, saturating.
- taken_cnt  out  CNT_W  count of cycles with taken=1, saturating.

Behaviour:
- A register match means regwrite=1, the destination register is nonzero, and the destination equals id_rs or id_rt. Register $0 never matches.
- Required stall count N (combinational), evaluated only when id_branch=1, first rule that applies:
  - EX is a load with a match: N=2.
  - EX is a non-load with a match: N=1.
  - MEM is a load with a match: N=1.
  - Otherwise: N=0.
- FSM states: IDLE and STALL2, registered.
- IDLE, id_branch=1, N>0:
  - stall=1, branch_valid=0, sel_a=sel_b=00.
  - Next state is STALL2 if N=2, else stay IDLE.
- IDLE, id_branch=1, N=0:
  - stall=0, branch_valid=1.
  - Per operand, sel=10 if MEM matches with mem_memread=0; else 01 if WB matches; else 00.
  - EX/MEM has priority over MEM/WB when both match.
- IDLE, id_branch=0: stall=0, branch_valid=0, sel=00.
- STALL2:
  - stall=1, branch_valid=0, sel=00.
  - Next state is IDLE unconditionally; the hazard is re-evaluated there, by which time the load is in WB and sel=01.
- hold=1: state and counters keep their values; outputs follow the current state.
- Latency:
  - ALU producer in EX: 1 stall cycle, then resolve with sel=10.
  - Load in EX: 2 stalls, then resolve with sel=01.
  - Load in MEM: 1 stall, then sel=01.
- stall_cycles increments on each non-hold cycle with stall=1; taken_cnt increments on each non-hold cycle with taken=1. Both saturate at 2^CNT_W-1 with no wrap.
- Reset behaviour:
  - On reset, state=IDLE and both counters=0.
  - Outputs during reset: stall=0, branch_valid=0, taken=0, if_flush=0, sel=00. Reset overrides hold.
  - Reset asserted while in STALL2 returns to IDLE the next cycle with no residual stall.
- Outputs are combinational from the state and current inputs; there are no registered outputs besides the counters.

Test Plan:
- Reset with hold=1 and id_branch=1 in STALL2 -> next cycle state IDLE, counters 0, stall=0.
- Branch rs=8, EX ALU rd=8 -> cycle 0: stall=1, sel_a=00. Cycle 1, producer now in MEM (mem_rd=8, mem_memread=0): sel_a=10, branch_valid=1. stall_cycles=1.
- beq rs=9, rt=10; EX load rd=10 -> stall for 2 cycles, then with wb_rd=10: sel_b=01, sel_a=00. With branch_eq=1: taken=1, if_flush=1, taken_cnt=1.
- Branch with rs=rt=0 and every stage writing rd=0 -> no stall, sel=00/00 (the $0 rule).
- rs=5 with mem_rd=5 (ALU) and wb_rd=5 -> sel_a=10 (priority); bne with branch_eq=1 -> taken=0.
- CNT_W=2: drive 5 stall cycles -> stall_cycles=3 (saturated). hold=1 during STALL2 for 3 cycles -> stall stays 1, counter frozen, state still STALL2.
